// File: rtl/csr_hpm_bank_pkg.sv
// Shared types, CSR addresses and helpers for the machine counter / HPM CSR bank.
package csr_hpm_bank_pkg;

    typedef enum logic [1:0] {
        CSR_WRITE = 2'd0,
        CSR_SET   = 2'd1,
        CSR_CLEAR = 2'd2
    } csrOperation_e;

    localparam logic [11:0] MCYCLE        = 12'hB00;
    localparam logic [11:0] MINSTRET      = 12'hB02;
    localparam logic [11:0] MHPMCOUNTER3  = 12'hB03;
    localparam logic [11:0] MCYCLEH       = 12'hB80;
    localparam logic [11:0] MINSTRETH     = 12'hB82;
    localparam logic [11:0] MHPMCOUNTER3H = 12'hB83;
    localparam logic [11:0] MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] MHPMEVENT3    = 12'h323;
    localparam logic [11:0] CYCLE         = 12'hC00;
    localparam logic [11:0] CYCLEH        = 12'hC80;
    localparam logic [11:0] INSTRET       = 12'hC02;
    localparam logic [11:0] INSTRETH      = 12'hC82;
    localparam logic [11:0] HPMCOUNTER3   = 12'hC03;
    localparam logic [11:0] HPMCOUNTER3H  = 12'hC83;

    // CY, IR and one bit per implemented HPM counter; TM (bit 1) is never implemented.
    function automatic logic [31:0] inhibit_mask(input int num_hpm);
        logic [31:0] m;
        m = 32'h0000_0005;
        for (int i = 3; i < 32; i++) begin
            if (i < num_hpm + 3) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

    function automatic logic [31:0] apply_op(input csrOperation_e op,
                                             input logic [31:0]   cur,
                                             input logic [31:0]   operand);
        logic [31:0] res;
        case (op)
            CSR_WRITE: res = operand;
            CSR_SET:   res = cur | operand;
            CSR_CLEAR: res = cur & ~operand;
            default:   res = cur;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/csr_hpm_bank_hpm_counter.sv
// One counter of the bank: split 32-bit half writes, +1 increment, one-cycle wrap pulse.
module hpm_counter #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_i,
    input  logic             wr_lo_i,
    input  logic             wr_hi_i,
    input  logic [31:0]      data_i,
    output logic [WIDTH-1:0] value_o,
    output logic             overflow_o
);

    logic [WIDTH-1:0] r_value;
    logic             r_overflow;

    // A CSR write to either half takes priority over that cycle's increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_value    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= 1'b0;
            if (wr_lo_i) begin
                r_value[31:0] <= data_i;
            end else if (wr_hi_i) begin
                r_value[WIDTH-1:32] <= data_i[WIDTH-33:0];
            end else if (inc_i) begin
                r_value    <= r_value + WIDTH'(1);
                r_overflow <= &r_value;
            end
        end
    end

    assign value_o    = r_value;
    assign overflow_o = r_overflow;

endmodule

// File: rtl/csr_hpm_bank.sv
// Machine counter / performance-monitor CSR bank: mcycle, minstret, mhpmcounterN,
// mhpmeventN and mcountinhibit, with address decode and a zero-latency read mux.
module csr_hpm_bank
    import csr_hpm_bank_pkg::*;
#(
    parameter int NUM_HPM       = 4,
    parameter int NUM_EVENTS    = 8,
    parameter int COUNTER_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  read_enable_i,
    input  logic                  write_enable_i,
    input  csrOperation_e         operation_i,
    input  logic [11:0]           address_i,
    input  logic [31:0]           data_i,
    input  logic                  killed,
    input  logic                  instret_i,
    input  logic [NUM_EVENTS-1:0] event_i,
    output logic [31:0]           out_o,
    output logic                  hit_o,
    output logic [NUM_HPM+2:0]    overflow_o
);

    localparam int          NC       = NUM_HPM + 3;
    localparam int          EW       = $clog2(NUM_EVENTS + 1);
    localparam logic [31:0] INH_MASK = inhibit_mask(NUM_HPM);
    localparam logic [EW-1:0] MAX_EVT = EW'(NUM_EVENTS);

    localparam logic [6:0] WIN_MLO = MCYCLE[11:5];
    localparam logic [6:0] WIN_MHI = MCYCLEH[11:5];
    localparam logic [6:0] WIN_ULO = CYCLE[11:5];
    localparam logic [6:0] WIN_UHI = CYCLEH[11:5];
    localparam logic [6:0] WIN_EVT = MCOUNTINHIBIT[11:5];

    logic [4:0]          w_idx;
    logic                w_idx_hpm;
    logic                w_idx_ctr;
    logic                w_is_mlo;
    logic                w_is_mhi;
    logic                w_hit_lo;
    logic                w_hit_hi;
    logic                w_hit_evt;
    logic                w_hit_inh;
    logic                w_writable;
    logic                w_wr;
    logic [31:0]         w_cnt_lo;
    logic [31:0]         w_cnt_hi;
    logic [EW-1:0]       w_evt_cur;
    logic [31:0]         w_cur;
    logic [31:0]         w_wdata;
    logic [EW-1:0]       w_evt_new;
    logic [NC-1:0]       w_inc;
    logic [NC-1:0]       w_wr_lo;
    logic [NC-1:0]       w_wr_hi;
    logic [NC-1:0]       w_ovf;
    logic                w_unused;
    logic [COUNTER_WIDTH-1:0] w_count [NC];

    logic [31:0]   r_inhibit;
    logic [EW-1:0] r_event [NC];

    // Counters live at index N of a 32-entry window; the low five address bits pick N.
    assign w_idx      = address_i[4:0];
    assign w_idx_hpm  = (w_idx >= 5'd3) && ({27'd0, w_idx} < 32'(NC));
    assign w_idx_ctr  = (w_idx == 5'd0) || (w_idx == 5'd2) || w_idx_hpm;
    assign w_is_mlo   = (address_i[11:5] == WIN_MLO);
    assign w_is_mhi   = (address_i[11:5] == WIN_MHI);
    assign w_hit_lo   = (w_is_mlo || (address_i[11:5] == WIN_ULO)) && w_idx_ctr;
    assign w_hit_hi   = (w_is_mhi || (address_i[11:5] == WIN_UHI)) && w_idx_ctr;
    assign w_hit_evt  = (address_i[11:5] == WIN_EVT) && w_idx_hpm;
    assign w_hit_inh  = (address_i == MCOUNTINHIBIT);
    assign hit_o      = w_hit_lo || w_hit_hi || w_hit_evt || w_hit_inh;
    assign w_writable = ((w_is_mlo || w_is_mhi) && w_idx_ctr) || w_hit_evt || w_hit_inh;
    assign w_wr       = write_enable_i && !killed && w_writable;

    always_comb begin
        w_cnt_lo  = '0;
        w_cnt_hi  = '0;
        w_evt_cur = '0;
        for (int i = 0; i < NC; i++) begin
            if (w_idx == 5'(i)) begin
                w_cnt_lo  = w_count[i][31:0];
                w_cnt_hi  = 32'(w_count[i][COUNTER_WIDTH-1:32]);
                w_evt_cur = r_event[i];
            end
        end
    end

    always_comb begin
        w_cur = '0;
        if (w_hit_lo) begin
            w_cur = w_cnt_lo;
        end else if (w_hit_hi) begin
            w_cur = w_cnt_hi;
        end else if (w_hit_evt) begin
            w_cur = 32'(w_evt_cur);
        end else if (w_hit_inh) begin
            w_cur = r_inhibit;
        end
    end

    assign out_o   = (read_enable_i && !killed && hit_o) ? w_cur : 32'd0;
    assign w_wdata = apply_op(operation_i, w_cur, data_i);

    // Event selectors out of range read back as "off".
    assign w_evt_new = (w_wdata[EW-1:0] > MAX_EVT) ? '0 : w_wdata[EW-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_inhibit <= '0;
            for (int i = 0; i < NC; i++) begin
                r_event[i] <= '0;
            end
        end else begin
            if (w_wr && w_hit_inh) begin
                r_inhibit <= w_wdata & INH_MASK;
            end
            for (int i = 3; i < NC; i++) begin
                if (w_wr && w_hit_evt && (w_idx == 5'(i))) begin
                    r_event[i] <= w_evt_new;
                end
            end
        end
    end

    // Increments use the inhibit/selector values registered before this cycle's write.
    always_comb begin
        w_inc   = '0;
        w_wr_lo = '0;
        w_wr_hi = '0;
        for (int i = 0; i < NC; i++) begin
            if (i != 1) begin
                w_wr_lo[i] = w_wr && w_is_mlo && w_idx_ctr && (w_idx == 5'(i));
                w_wr_hi[i] = w_wr && w_is_mhi && w_idx_ctr && (w_idx == 5'(i));
            end
        end
        w_inc[0] = !r_inhibit[0];
        w_inc[2] = instret_i && !r_inhibit[2];
        for (int i = 3; i < NC; i++) begin
            for (int k = 0; k < NUM_EVENTS; k++) begin
                if ((r_event[i] == EW'(k + 1)) && event_i[k]) begin
                    w_inc[i] = !r_inhibit[i];
                end
            end
        end
    end

    assign w_unused = w_inc[1] | w_wr_lo[1] | w_wr_hi[1];

    genvar g;
    for (g = 0; g < NC; g++) begin : g_ctr
        if (g == 1) begin : g_hole
            assign w_count[g] = '0;
            assign w_ovf[g]   = 1'b0;
        end else begin : g_impl
            hpm_counter #(
                .WIDTH (COUNTER_WIDTH)
            ) u_counter (
                .clk        (clk),
                .reset      (reset),
                .inc_i      (w_inc[g]),
                .wr_lo_i    (w_wr_lo[g]),
                .wr_hi_i    (w_wr_hi[g]),
                .data_i     (w_wdata),
                .value_o    (w_count[g]),
                .overflow_o (w_ovf[g])
            );
        end
    end

    assign overflow_o = w_ovf;

endmodule
